// File: rtl/rv32_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: opcodes,
// controller states, instruction classes and datapath select encodings.
package rv32_pkg;

  // Base opcodes (instruction bits [6:0])
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Controller states, kept as plain constants so the encoding is visible
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_DECODE    = 3'd2;
  localparam logic [2:0] ST_EXECUTE   = 3'd3;
  localparam logic [2:0] ST_MEM       = 3'd4;
  localparam logic [2:0] ST_WRITEBACK = 3'd5;
  localparam logic [2:0] ST_TRAP      = 3'd6;

  // Instruction classes latched at the end of DECODE
  typedef enum logic [3:0] {
    CLS_R      = 4'd0,
    CLS_I_ALU  = 4'd1,
    CLS_LOAD   = 4'd2,
    CLS_STORE  = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_JAL    = 4'd5,
    CLS_JALR   = 4'd6,
    CLS_LUI    = 4'd7,
    CLS_AUIPC  = 4'd8,
    CLS_FENCE  = 4'd9,
    CLS_SYSTEM = 4'd10
  } instr_class_e;

  // ALU operand A select
  localparam logic       ALU_A_RS1 = 1'b0;
  localparam logic       ALU_A_PC  = 1'b1;

  // ALU operand B select
  localparam logic [1:0] ALU_B_RS2  = 2'b00;
  localparam logic [1:0] ALU_B_IMM  = 2'b01;
  localparam logic [1:0] ALU_B_FOUR = 2'b10;

  // Immediate format select
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  // ALU operation class
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_CMP   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // Register file write-back source
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // Memory access size
  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b01;
  localparam logic [1:0] MODE_WORD = 2'b10;

  // Trap causes
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ECALL    = 2'b11;

  // Natural alignment of an access of the given size at the given low address bits
  function automatic logic is_aligned(input logic [1:0] mode, input logic [1:0] lsb);
    case (mode)
      MODE_HALF: is_aligned = ~lsb[0];
      MODE_WORD: is_aligned = (lsb == 2'b00);
      default:   is_aligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/instr_classifier.sv
// Combinational RV32I classifier: maps opcode/funct3/funct7 onto an
// instruction class and flags encodings the core does not implement.
module instr_classifier
  import rv32_pkg::*;
(
  input  logic [6:0]   opcode_i,
  input  logic [2:0]   funct3_i,
  input  logic [6:0]   funct7_i,
  output instr_class_e class_o,
  output logic         illegal_o
);

  logic f7_zero;
  logic f7_alt;
  logic f3_alt_ok;

  assign f7_zero   = (funct7_i == 7'b0000000);
  assign f7_alt    = (funct7_i == 7'b0100000);
  // Only ADD/SUB and SRL/SRA have an alternate (funct7 = 0100000) form
  assign f3_alt_ok = (funct3_i == 3'b000) || (funct3_i == 3'b101);

  // Opcode decode with per-class encoding legality
  always_comb begin
    class_o   = CLS_R;
    illegal_o = 1'b0;
    case (opcode_i)
      OPC_OP: begin
        class_o   = CLS_R;
        illegal_o = ~(f7_zero | (f7_alt & f3_alt_ok));
      end
      OPC_OP_IMM: begin
        class_o = CLS_I_ALU;
        if (funct3_i == 3'b001) begin
          illegal_o = ~f7_zero;
        end else if (funct3_i == 3'b101) begin
          illegal_o = ~(f7_zero | f7_alt);
        end
      end
      OPC_LOAD: begin
        class_o   = CLS_LOAD;
        illegal_o = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11);
      end
      OPC_STORE: begin
        class_o   = CLS_STORE;
        illegal_o = (funct3_i >= 3'b011);
      end
      OPC_BRANCH: begin
        class_o   = CLS_BRANCH;
        illegal_o = (funct3_i[2:1] == 2'b01);
      end
      OPC_JAL:      class_o = CLS_JAL;
      OPC_JALR:     class_o = CLS_JALR;
      OPC_LUI:      class_o = CLS_LUI;
      OPC_AUIPC:    class_o = CLS_AUIPC;
      OPC_MISC_MEM: class_o = CLS_FENCE;
      OPC_SYSTEM:   class_o = CLS_SYSTEM;
      default:      illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencing controller. Steps each instruction through
// FETCH/DECODE/EXECUTE/MEM/WRITEBACK over one shared valid/ready memory
// port and halts in TRAP on illegal, misaligned or timed-out accesses.
module multicycle_control
  import rv32_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TO_W        = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic [1:0] addr_lsb_i,
  input  logic       branch_taken_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_write_o,
  output logic [1:0] mem_mode_o,
  output logic       mem_unsigned_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] imm_sel_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] result_src_o,
  output logic       trap_o,
  output logic [1:0] trap_cause_o
);

  // A disabled timeout still needs a legal (1-bit) counter
  localparam int unsigned CNT_W = (TO_W < 1) ? 1 : TO_W;

  logic [2:0]       state_q, state_d;
  instr_class_e     class_q, class_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;

  instr_class_e     dec_class;
  logic             dec_illegal;
  logic             mem_fire;
  logic             timeout_hit;

  instr_classifier u_classifier (
    .opcode_i  (opcode_i),
    .funct3_i  (funct3_i),
    .funct7_i  (funct7_i),
    .class_o   (dec_class),
    .illegal_o (dec_illegal)
  );

  assign mem_fire    = mem_req_o & mem_ready_i;
  // Ready in the limit cycle still completes the access, so it masks the trap
  assign timeout_hit = (MEM_TIMEOUT != 0) && mem_req_o && !mem_ready_i &&
                       (32'(to_cnt_q) == MEM_TIMEOUT);

  // Next-state, class latch and trap cause selection
  always_comb begin
    state_d = state_q;
    class_d = class_q;
    cause_d = cause_q;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_fire) begin
          state_d = ST_DECODE;
        end else if (timeout_hit) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_DECODE: begin
        class_d = dec_class;
        if (dec_illegal) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else if (dec_class == CLS_SYSTEM) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ECALL;
        end else if (dec_class == CLS_FENCE) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        case (class_q)
          CLS_LOAD, CLS_STORE: begin
            if (!is_aligned(funct3_i[1:0], addr_lsb_i)) begin
              state_d = ST_TRAP;
              cause_d = CAUSE_MISALIGN;
            end else begin
              state_d = ST_MEM;
            end
          end
          CLS_R, CLS_I_ALU, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR:
            state_d = ST_WRITEBACK;
          default: state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (mem_fire) begin
          state_d = (class_q == CLS_LOAD) ? ST_WRITEBACK : ST_FETCH;
        end else if (timeout_hit) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_WRITEBACK: state_d = ST_FETCH;
      ST_TRAP:      state_d = ST_TRAP;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Wait-cycle counter: runs only while a request stalls in the same state
  always_comb begin
    to_cnt_d = '0;
    if ((MEM_TIMEOUT != 0) && mem_req_o && !mem_ready_i && (state_d == state_q)) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  // Moore output decode from state and latched class; handshake-qualified strobes in FETCH
  always_comb begin
    mem_req_o      = 1'b0;
    mem_write_o    = 1'b0;
    mem_mode_o     = MODE_BYTE;
    mem_unsigned_o = 1'b0;
    ir_write_o     = 1'b0;
    pc_write_o     = 1'b0;
    reg_write_o    = 1'b0;
    alu_src_a_o    = ALU_A_RS1;
    alu_src_b_o    = ALU_B_RS2;
    imm_sel_o      = IMM_I;
    alu_op_o       = ALU_OP_ADD;
    result_src_o   = RES_ALU;
    trap_o         = 1'b0;
    trap_cause_o   = CAUSE_ILLEGAL;
    case (state_q)
      ST_FETCH: begin
        mem_req_o  = 1'b1;
        mem_mode_o = MODE_WORD;
        ir_write_o = mem_ready_i;
        pc_write_o = mem_ready_i;
      end
      ST_EXECUTE: begin
        case (class_q)
          CLS_R: alu_op_o = ALU_OP_FUNCT;
          CLS_I_ALU: begin
            alu_src_b_o = ALU_B_IMM;
            alu_op_o    = ALU_OP_FUNCT;
          end
          CLS_LOAD:  alu_src_b_o = ALU_B_IMM;
          CLS_STORE: begin
            alu_src_b_o = ALU_B_IMM;
            imm_sel_o   = IMM_S;
          end
          CLS_BRANCH: begin
            imm_sel_o  = IMM_B;
            alu_op_o   = ALU_OP_CMP;
            pc_write_o = branch_taken_i;
          end
          CLS_JAL: begin
            alu_src_a_o = ALU_A_PC;
            alu_src_b_o = ALU_B_IMM;
            imm_sel_o   = IMM_J;
            pc_write_o  = 1'b1;
          end
          CLS_JALR: begin
            alu_src_b_o = ALU_B_IMM;
            pc_write_o  = 1'b1;
          end
          CLS_LUI: begin
            alu_src_b_o = ALU_B_IMM;
            imm_sel_o   = IMM_U;
          end
          CLS_AUIPC: begin
            alu_src_a_o = ALU_A_PC;
            alu_src_b_o = ALU_B_IMM;
            imm_sel_o   = IMM_U;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        mem_req_o      = 1'b1;
        mem_write_o    = (class_q == CLS_STORE);
        mem_mode_o     = funct3_i[1:0];
        mem_unsigned_o = funct3_i[2];
      end
      ST_WRITEBACK: begin
        reg_write_o = 1'b1;
        if (class_q == CLS_LOAD) begin
          result_src_o = RES_MEM;
        end else if ((class_q == CLS_JAL) || (class_q == CLS_JALR)) begin
          result_src_o = RES_PC4;
        end
      end
      ST_TRAP: begin
        trap_o       = 1'b1;
        trap_cause_o = cause_q;
      end
      default: ;
    endcase
  end

  // Control state registers; reset returns to IDLE and drops any request at once
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      class_q  <= CLS_R;
      cause_q  <= CAUSE_ILLEGAL;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      class_q  <= class_d;
      cause_q  <= cause_d;
      to_cnt_q <= to_cnt_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed cases followed by random
// instruction streams, each checked cycle by cycle against a reference
// model that derives the expected output trace from the instruction rules.
module tb_multicycle_control;

  localparam int TMO = 4;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [6:0] opcode_i = '0;
  logic [2:0] funct3_i = '0;
  logic [6:0] funct7_i = '0;
  logic [1:0] addr_lsb_i = '0;
  logic       branch_taken_i = 1'b0;
  logic       mem_ready_i = 1'b0;
  logic       mem_req_o, mem_write_o, mem_unsigned_o;
  logic [1:0] mem_mode_o;
  logic       ir_write_o, pc_write_o, reg_write_o, alu_src_a_o;
  logic [1:0] alu_src_b_o, alu_op_o, result_src_o, trap_cause_o;
  logic [2:0] imm_sel_o;
  logic       trap_o;

  multicycle_control #(.MEM_TIMEOUT(TMO)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .opcode_i       (opcode_i),
    .funct3_i       (funct3_i),
    .funct7_i       (funct7_i),
    .addr_lsb_i     (addr_lsb_i),
    .branch_taken_i (branch_taken_i),
    .mem_ready_i    (mem_ready_i),
    .mem_req_o      (mem_req_o),
    .mem_write_o    (mem_write_o),
    .mem_mode_o     (mem_mode_o),
    .mem_unsigned_o (mem_unsigned_o),
    .ir_write_o     (ir_write_o),
    .pc_write_o     (pc_write_o),
    .reg_write_o    (reg_write_o),
    .alu_src_a_o    (alu_src_a_o),
    .alu_src_b_o    (alu_src_b_o),
    .imm_sel_o      (imm_sel_o),
    .alu_op_o       (alu_op_o),
    .result_src_o   (result_src_o),
    .trap_o         (trap_o),
    .trap_cause_o   (trap_cause_o)
  );

  always #5 clk_i = ~clk_i;

  // All outputs of one cycle, packed for a single comparison
  typedef struct packed {
    logic       req;
    logic       wr;
    logic [1:0] mode;
    logic       uns;
    logic       irw;
    logic       pcw;
    logic       rw;
    logic       a;
    logic [1:0] b;
    logic [2:0] imm;
    logic [1:0] op;
    logic [1:0] res;
    logic       trap;
    logic [1:0] cause;
  } outs_t;

  typedef struct packed {
    outs_t o;
    logic  rdy;
  } rec_t;

  outs_t obs;
  assign obs = {mem_req_o, mem_write_o, mem_mode_o, mem_unsigned_o, ir_write_o,
                pc_write_o, reg_write_o, alu_src_a_o, alu_src_b_o, imm_sel_o,
                alu_op_o, result_src_o, trap_o, trap_cause_o};

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5,
                 K_JALR = 6, K_LUI = 7, K_AUIPC = 8, K_FENCE = 9, K_SYS = 10,
                 K_ILL = 11;

  int   n_cmp = 0;
  int   n_bad = 0;
  rec_t q[$];
  logic [6:0] ops [11] = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37,
                           7'h17, 7'h13, 7'h33, 7'h0F, 7'h73};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Instruction kind from the RV32I encoding rules
  function automatic int classify(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    case (op)
      7'h33: return (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) ? K_R : K_ILL;
      7'h13: begin
        if (f3 == 3'd1) return (f7 == 7'h00) ? K_I : K_ILL;
        if (f3 == 3'd5) return (f7 == 7'h00 || f7 == 7'h20) ? K_I : K_ILL;
        return K_I;
      end
      7'h03: return (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ? K_ILL : K_LD;
      7'h23: return (f3 <= 3'd2) ? K_ST : K_ILL;
      7'h63: return (f3 == 3'd2 || f3 == 3'd3) ? K_ILL : K_BR;
      7'h6F: return K_JAL;
      7'h67: return K_JALR;
      7'h37: return K_LUI;
      7'h17: return K_AUIPC;
      7'h0F: return K_FENCE;
      7'h73: return K_SYS;
      default: return K_ILL;
    endcase
  endfunction

  // Datapath selects expected while an instruction of this kind executes
  function automatic outs_t exec_outs(input int kind, input logic taken);
    outs_t o;
    o = '0;
    case (kind)
      K_R:     o.op = 2'b10;
      K_I:     begin o.b = 2'b01; o.op = 2'b10; end
      K_LD:    o.b = 2'b01;
      K_ST:    begin o.b = 2'b01; o.imm = 3'b001; end
      K_BR:    begin o.imm = 3'b010; o.op = 2'b01; o.pcw = taken; end
      K_JAL:   begin o.a = 1'b1; o.b = 2'b01; o.imm = 3'b100; o.pcw = 1'b1; end
      K_JALR:  begin o.b = 2'b01; o.pcw = 1'b1; end
      K_LUI:   begin o.b = 2'b01; o.imm = 3'b011; end
      K_AUIPC: begin o.a = 1'b1; o.b = 2'b01; o.imm = 3'b011; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic push(input outs_t o, input logic r);
    rec_t e;
    e.o   = o;
    e.rdy = r;
    q.push_back(e);
  endtask

  // One memory request: 'waits' stall cycles before ready, trapping at the limit
  task automatic add_req(input outs_t wait_o, input outs_t done_o, input int waits,
                         output bit timed_out);
    timed_out = 1'b0;
    for (int k = 0; k <= waits; k++) begin
      if (k == waits) begin
        push(done_o, 1'b1);
        return;
      end
      push(wait_o, 1'b0);
      if (TMO != 0 && k == TMO) begin
        timed_out = 1'b1;
        return;
      end
    end
  endtask

  // Build the expected trace for one instruction, then play it against the DUT
  task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [1:0] lsb, input logic taken,
                           input int wf, input int wm, output bit trapped);
    outs_t w, d, t;
    int    kind;
    int    size;
    bit    to;
    logic [1:0] cause;
    q.delete();
    trapped = 1'b0;
    cause   = 2'b00;
    opcode_i = op; funct3_i = f3; funct7_i = f7;
    addr_lsb_i = lsb; branch_taken_i = taken;
    w = '0; w.req = 1'b1; w.mode = 2'b10;
    d = w;  d.irw = 1'b1; d.pcw = 1'b1;
    add_req(w, d, wf, to);
    if (to) begin
      trapped = 1'b1; cause = 2'b10;
    end else begin
      push('0, 1'($urandom_range(1)));
      kind = classify(op, f3, f7);
      if (kind == K_ILL) begin
        trapped = 1'b1; cause = 2'b00;
      end else if (kind == K_SYS) begin
        trapped = 1'b1; cause = 2'b11;
      end else if (kind != K_FENCE) begin
        push(exec_outs(kind, taken), 1'($urandom_range(1)));
        if (kind == K_LD || kind == K_ST) begin
          size = 1 << f3[1:0];
          if ((int'(lsb) % size) != 0) begin
            trapped = 1'b1; cause = 2'b01;
          end else begin
            w = '0; w.req = 1'b1; w.wr = (kind == K_ST);
            w.mode = f3[1:0]; w.uns = f3[2];
            add_req(w, w, wm, to);
            if (to) begin
              trapped = 1'b1; cause = 2'b10;
            end else if (kind == K_LD) begin
              t = '0; t.rw = 1'b1; t.res = 2'b01;
              push(t, 1'($urandom_range(1)));
            end
          end
        end else if (kind != K_BR) begin
          t = '0; t.rw = 1'b1;
          t.res = (kind == K_JAL || kind == K_JALR) ? 2'b10 : 2'b00;
          push(t, 1'($urandom_range(1)));
        end
      end
    end
    if (trapped) begin
      t = '0; t.trap = 1'b1; t.cause = cause;
      repeat (20) push(t, 1'($urandom_range(1)));
    end
    foreach (q[i]) begin
      mem_ready_i = q[i].rdy;
      @(negedge clk_i);
      check_val($sformatf("%s c%0d", tag, i), 32'(obs), 32'(q[i].o));
      @(posedge clk_i);
      #1;
    end
  endtask

  // Asynchronous reset mid-cycle, then the single IDLE cycle after release
  task automatic reset_dut();
    mem_ready_i = 1'b0;
    rst_i = 1'b1;
    #1;
    check_val("rst_outs", 32'(obs), 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    mem_ready_i = 1'($urandom_range(1));
    @(negedge clk_i);
    check_val("idle_outs", 32'(obs), 32'd0);
    @(posedge clk_i);
    #1;
  endtask

  // Closing a program that did not trap: the core sits in FETCH with a live request
  task automatic end_prog(input bit trapped);
    if (!trapped) check_val("req_before_rst", 32'(mem_req_o), 32'd1);
  endtask

  initial begin
    bit tr;
    logic [6:0] op;
    logic [6:0] f7;
    #2;

    reset_dut();
    run_instr("add", 7'h33, 3'd0, 7'h00, 2'b00, 1'b0, 0, 0, tr);
    end_prog(tr);

    reset_dut();
    run_instr("lw_wait3", 7'h03, 3'd2, 7'h00, 2'b00, 1'b0, 0, 3, tr);
    end_prog(tr);

    reset_dut();
    run_instr("sh_misal", 7'h23, 3'd1, 7'h00, 2'b01, 1'b0, 0, 0, tr);
    end_prog(tr);

    reset_dut();
    run_instr("fetch_tmo", 7'h33, 3'd0, 7'h00, 2'b00, 1'b0, TMO + 1, 0, tr);
    end_prog(tr);

    reset_dut();
    run_instr("fetch_late", 7'h33, 3'd0, 7'h00, 2'b00, 1'b0, TMO, 0, tr);
    end_prog(tr);

    reset_dut();
    run_instr("illegal_7f", 7'h7F, 3'd0, 7'h00, 2'b00, 1'b0, 0, 0, tr);
    end_prog(tr);

    reset_dut();
    run_instr("ecall", 7'h73, 3'd0, 7'h00, 2'b00, 1'b0, 0, 0, tr);
    end_prog(tr);

    reset_dut();
    run_instr("beq_t", 7'h63, 3'd0, 7'h00, 2'b00, 1'b1, 0, 0, tr);
    run_instr("beq_nt", 7'h63, 3'd0, 7'h00, 2'b00, 1'b0, 0, 0, tr);
    end_prog(tr);

    for (int p = 0; p < 40; p++) begin
      reset_dut();
      tr = 1'b0;
      for (int n = 0; n < 6 && !tr; n++) begin
        op = ($urandom_range(11) == 0) ? 7'($urandom) : ops[$urandom_range(10)];
        f7 = ($urandom_range(3) == 0) ? 7'($urandom) :
             (($urandom_range(1) == 1) ? 7'h20 : 7'h00);
        run_instr($sformatf("rnd%0d_%0d", p, n), op, 3'($urandom), f7,
                  2'($urandom), 1'($urandom), 
                  ($urandom_range(3) == 0) ? int'($urandom_range(TMO + 2)) : 0,
                  ($urandom_range(3) == 0) ? int'($urandom_range(TMO + 2)) : 0, tr);
      end
      end_prog(tr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
